// File: rtl/alphamission_sprite_linebuf.sv
// Double-buffered 256-pixel sprite line buffer with clear-on-read display side.
// Optional macro LINEBUF_PRIORITY_EN: first opaque writer to a pixel wins.
module alphamission_sprite_linebuf #(
    parameter logic [7:0] CLEAR_VAL  = 8'hFF,
    parameter logic [3:0] TRANSP_NIB = 4'hF,
    parameter logic [7:0] H_START    = 8'd0
) (
    input  logic       clk,
    input  logic       VIDEO_RSTn,
    input  logic       CK1,
    input  logic       LINE_START,
    input  logic       WR_EN,
    input  logic [7:0] WR_X,
    input  logic [7:0] WR_D,
    output logic [7:0] LD,
    output logic       BANK,
    output logic       BUSY
);

    typedef enum logic {
        S_CLR,
        S_RUN
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_clr_cnt;
    logic [7:0] r_rd_x;
    logic [7:0] r_ld;
    logic       r_bank;

    logic [7:0] r_mem0 [256];
    logic [7:0] r_mem1 [256];

    logic       w_run;
    logic       w_tick;
    logic       w_opaque;
    logic       w_wr_ok;
    logic       w_draw_we;
    logic [7:0] w_disp_q;

    logic       w_we   [2];
    logic [7:0] w_addr [2];
    logic [7:0] w_wdat [2];

    assign w_run    = (r_state == S_RUN);
    assign w_tick   = w_run && CK1 && !LINE_START;
    assign w_opaque = (WR_D[3:0] != TRANSP_NIB);
    assign w_disp_q = r_bank ? r_mem1[r_rd_x] : r_mem0[r_rd_x];

`ifdef LINEBUF_PRIORITY_EN
    logic [7:0] w_draw_q;
    // Pixel already owned by an earlier sprite blocks later writers.
    assign w_draw_q = r_bank ? r_mem0[WR_X] : r_mem1[WR_X];
    assign w_wr_ok  = w_opaque && (w_draw_q == CLEAR_VAL);
`else
    assign w_wr_ok  = w_opaque;
`endif

    assign w_draw_we = w_run && WR_EN && w_wr_ok;

    // One write port per bank: clear, clear-on-read or draw.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_we[b]   = 1'b0;
            w_addr[b] = r_clr_cnt;
            w_wdat[b] = CLEAR_VAL;
        end
        if (!w_run) begin
            w_we[0] = 1'b1;
            w_we[1] = 1'b1;
        end else begin
            w_we[r_bank]    = w_tick;
            w_addr[r_bank]  = r_rd_x;
            w_we[!r_bank]   = w_draw_we;
            w_addr[!r_bank] = WR_X;
            w_wdat[!r_bank] = WR_D;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we[0]) begin
            r_mem0[w_addr[0]] <= w_wdat[0];
        end
        if (w_we[1]) begin
            r_mem1[w_addr[1]] <= w_wdat[1];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_CLR: begin
                if (r_clr_cnt == 8'hFF) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_CLR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge VIDEO_RSTn) begin
        if (!VIDEO_RSTn) begin
            r_state   <= S_CLR;
            r_clr_cnt <= 8'd0;
            r_bank    <= 1'b0;
            r_rd_x    <= H_START;
            r_ld      <= CLEAR_VAL;
        end else begin
            r_state <= w_state_nxt;
            if (!w_run) begin
                r_clr_cnt <= r_clr_cnt + 8'd1;
                r_ld      <= CLEAR_VAL;
            end else if (LINE_START) begin
                // Reload beats a coincident pixel tick.
                r_bank <= ~r_bank;
                r_rd_x <= H_START;
            end else if (CK1) begin
                r_ld   <= w_disp_q;
                r_rd_x <= r_rd_x + 8'd1;
            end
        end
    end

    assign LD   = r_ld;
    assign BANK = r_bank;
    assign BUSY = !w_run;

endmodule

// File: tb/tb_alphamission_sprite_linebuf.sv
// Scoreboard bench for alphamission_sprite_linebuf with a behavioural line model.
module tb_alphamission_sprite_linebuf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ck1 = 1'b0;
    logic       ls = 1'b0;
    logic       we = 1'b0;
    logic [7:0] wx = 8'd0;
    logic [7:0] wd = 8'd0;
    logic [7:0] ld;
    logic       bank;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] ld;
        logic       busy;
        logic       bank;
    } exp_t;

    exp_t q[$];

    alphamission_sprite_linebuf dut (
        .clk       (clk),
        .VIDEO_RSTn(rst_n),
        .CK1       (ck1),
        .LINE_START(ls),
        .WR_EN     (we),
        .WR_X      (wx),
        .WR_D      (wd),
        .LD        (ld),
        .BANK      (bank),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    // Reference model: two pixel lines, a clear countdown and a read cursor.
    logic [7:0] m_mem [2][256];
    bit         m_busy = 1'b1;
    int         m_clr = 0;
    int         m_bank = 0;
    int         m_rdx = 0;
    logic [7:0] m_ld = 8'hFF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b1;
            m_clr  = 0;
            m_bank = 0;
            m_rdx  = 0;
            m_ld   = 8'hFF;
        end else if (m_busy) begin
            m_mem[0][m_clr] = 8'hFF;
            m_mem[1][m_clr] = 8'hFF;
            m_clr = m_clr + 1;
            if (m_clr == 256) m_busy = 1'b0;
        end else begin
            if (we && wd[3:0] != 4'hF) begin
`ifdef LINEBUF_PRIORITY_EN
                if (m_mem[1-m_bank][wx] == 8'hFF) m_mem[1-m_bank][wx] = wd;
`else
                m_mem[1-m_bank][wx] = wd;
`endif
            end
            if (ls) begin
                m_bank = 1 - m_bank;
                m_rdx  = 0;
            end else if (ck1) begin
                m_ld = m_mem[m_bank][m_rdx];
                m_mem[m_bank][m_rdx] = 8'hFF;
                m_rdx = (m_rdx + 1) % 256;
            end
        end
        if (clk) q.push_back('{m_ld, m_busy, m_bank[0]});
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if (ld !== e.ld || busy !== e.busy || bank !== e.bank) begin
                miscompares++;
                $display("FAIL out t=%0t got LD=%h BUSY=%b BANK=%b want LD=%h BUSY=%b BANK=%b",
                         $time, ld, busy, bank, e.ld, e.busy, e.bank);
            end
        end
    end

    function automatic logic rbit(input int pct);
        return 1'($urandom_range(0, 99) < pct);
    endfunction

    task automatic cyc(input logic c, input logic l, input logic w,
                       input logic [7:0] x, input logic [7:0] d);
        ck1 = c;
        ls  = l;
        we  = w;
        wx  = x;
        wd  = d;
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic swap();
        cyc(1'b0, 1'b1, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic wr(input logic [7:0] x, input logic [7:0] d);
        cyc(1'b0, 1'b0, 1'b1, x, d);
    endtask

    // Count clocks with BUSY high, with random traffic that must be ignored.
    task automatic clear_wait();
        int cnt;
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            cyc(rbit(50), rbit(10), rbit(50), 8'($urandom), 8'($urandom));
        end
        vectors++;
        if (cnt != 256) begin
            miscompares++;
            $display("FAIL busy_len got %0d clks want 256", cnt);
        end
    endtask

    initial begin
        @(negedge clk);
        #1;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
        clear_wait();
        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

        // Both banks read back as cleared.
        ticks(257);
        swap();
        ticks(257);
        swap();

        // Single pixel, then clear-on-read on the next pass.
        wr(8'd10, 8'h23);
        swap();
        ticks(12);
        swap();
        swap();
        ticks(12);

        // Transparent nibble discarded.
        wr(8'd5, 8'h4F);
        swap();
        ticks(8);

        // Two writers to one pixel.
        wr(8'd7, 8'h11);
        wr(8'd7, 8'h22);
        swap();
        ticks(9);

        // Coincident swap and tick at rd_x=100, with a write in the same clk.
        swap();
        ticks(100);
        cyc(1'b1, 1'b1, 1'b1, 8'd3, 8'h5A);
        ticks(6);

        // Full wrap without a swap.
        swap();
        ticks(256);
        ticks(256);

        // Opaque pixel on LD, then asynchronous reset mid-line.
        wr(8'd2, 8'h31);
        swap();
        ticks(3);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (ld !== 8'hFF || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL async_rst got LD=%h BUSY=%b want LD=ff BUSY=1", ld, busy);
        end
        @(negedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        rst_n = 1'b1;
        clear_wait();

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (rbit(20)) d[3:0] = 4'hF;
            cyc(rbit(50), rbit(1), rbit(50), 8'($urandom), d);
        end

        cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
